muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide execute unit; multi-cycle counterpart to the
//   single-cycle ALU. Accepts operands plus funct3 from the execute stage when
//   control decodes OP with funct7=0000001.
//   Produces one 32-bit result per operation over a start/busy/done handshake
//   that the pipeline uses to stall.
// PARAMETERS
//   XLEN  32  operand/result width; only 32 is supported
// PORTS
//   clk     in   1     single clock, rising edge
//   rst     in   1     synchronous, active-high reset
//   start   in   1     request; accepted only when busy=0
//   funct3  in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   read1   in   32    rs1 operand (multiplicand / dividend)
//   read2   in   32    rs2 operand (multiplier / divisor)
//   busy    out  1     high from the cycle after acceptance through the done cycle
//   done    out  1     one-cycle pulse: out is valid
//   out     out  32    result; held stable from done until the next accepted start
// BEHAVIOUR
//   - Reset: state=IDLE, busy=0, done=0, out=0. Reset asserted mid-operation
//     aborts it; no done pulse follows.
//   - FSM: IDLE -(start)-> CALC (XLEN cycles) -> FIX (1 cycle) -> DONE (1 cycle) -> IDLE.
//   - Handshake: start sampled in IDLE only; start while busy is ignored and
//     does not queue. funct3/read1/read2 are latched on acceptance and may
//     change afterwards. done rises exactly XLEN+2 = 34 cycles after the
//     accepting edge. A start in the cycle after done is accepted (back-to-back).
//   - Multiply: radix-2 shift-add on 33-bit sign/zero-extended operands, 64-bit
//     product. MUL -> product[31:0]; MULH s*s, MULHSU s*u, MULHU u*u -> product[63:32].
//   - Divide: restoring, magnitude-based. Signed ops take |operands|, and FIX
//     negates the quotient if the signs differ and the remainder if the dividend
//     is negative. Results are truncated toward zero.
//   - Divide by zero: DIV/DIVU -> 32'hFFFFFFFF; REM/REMU -> read1. Latency is unchanged.
//   - Signed overflow (read1=32'h80000000, read2=-1): DIV -> 32'h80000000; REM -> 0.
//   - Latency is data-independent for every op and corner case.
//   - out changes only on the DONE cycle (and on reset).
// CONFIGURATION
//   MULDIV_FAST_MUL_EN defined: all multiply ops bypass CALC. The product comes
//     from one 64-bit `*` registered in FIX, so done arrives 2 cycles after
//     acceptance. Divide timing is unchanged.
//   undefined: all ops are iterative with the 34-cycle latency; no hard multiplier.
// STRUCTURE
//   - defs.v gains M_MUL..M_REMU funct3 constants, OPCODE_M_ALU, FUNCT7_MULDIV
//     and MULDIV_ST_IDLE/CALC/FIX/DONE state encodings.
//   - One sub-module, muldiv_step: combinational single iteration. It performs
//     one add-or-pass (mul) or trial-subtract (div) on the {hi,lo} accumulator.
//   - The FSM, counter, sign handling and output register live in the top module.
// TESTING
//   - MUL 7*-3: read1=7, read2=32'hFFFFFFFD, funct3=000 -> out=32'hFFFFFFEB,
//     done exactly 34 cycles after start.
//   - MULHU/MULH 32'hFFFFFFFF x 32'hFFFFFFFF: MULHU -> 32'hFFFFFFFE, MULH -> 0,
//     MULHSU -> 32'hFFFFFFFF.
//   - DIV/REM -7/2 -> 32'hFFFFFFFD / 32'hFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//   - Divide by zero: DIV 5/0 -> 32'hFFFFFFFF, REMU 5/0 -> 5. Overflow:
//     DIV 32'h80000000/-1 -> 32'h80000000, REM -> 0.
//   - Handshake: start pulsed again at cycles 5 and 20 of a running op -> ignored.
//     Back-to-back start the cycle after done -> accepted, and out holds until
//     the new done.
//   - Reset at cycle 10 of a DIV: busy=0, out=0, no done. A following MUL
//     completes correctly. Repeat all cases with MULDIV_FAST_MUL_EN (mul latency 2).

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, decode
// constants, FSM state encodings and small helpers.
package muldiv_unit_pkg;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    localparam logic [6:0] OPCODE_M_ALU  = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        MULDIV_ST_IDLE = 2'd0,
        MULDIV_ST_CALC = 2'd1,
        MULDIV_ST_FIX  = 2'd2,
        MULDIV_ST_DONE = 2'd3
    } muldiv_state_t;

    function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPCODE_M_ALU) && (funct7 == FUNCT7_MULDIV);
    endfunction

    // Magnitude of a value that is two's complement only when sgn is set.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration on the {hi,lo} accumulator: shift-add for multiply,
// restoring trial-subtract for divide.
module muldiv_step (
    input  logic        is_div,
    input  logic [32:0] hi,
    input  logic [31:0] lo,
    input  logic [32:0] opnd,
    output logic [32:0] hi_next,
    output logic [31:0] lo_next
);

    logic [33:0] sum;
    logic [32:0] shifted;
    logic [33:0] diff;

    always_comb begin
        sum     = {hi[32], hi} + (lo[0] ? {opnd[32], opnd} : 34'd0);
        shifted = {hi[31:0], lo[31]};
        diff    = {1'b0, shifted} - {1'b0, opnd};
        hi_next = sum[33:1];
        lo_next = {sum[0], lo[31:1]};
        if (is_div) begin
            if (!diff[33]) begin
                hi_next = diff[32:0];
                lo_next = {lo[30:0], 1'b1};
            end else begin
                hi_next = shifted;
                lo_next = {lo[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle hard multiplier.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] read1,
    input  logic [XLEN-1:0] read2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out
);

    muldiv_state_t state, state_next;

    logic [4:0]  cnt;
    logic [2:0]  op_r;
    logic [31:0] a_r, b_r;
    logic [32:0] hi_r, opnd_r, hi_next;
    logic [31:0] lo_r, lo_next;
    logic        neg_q, neg_r;
    logic [31:0] res_r, res_fix, mul_lo, mul_hi;
    logic        accept, fast_path;

    assign accept = start && (state == MULDIV_ST_IDLE) && !done;
    assign busy   = (state != MULDIV_ST_IDLE) || done;

`ifdef MULDIV_FAST_MUL_EN
    assign fast_path = !funct3[2];
`else
    assign fast_path = 1'b0;
`endif

    muldiv_step u_step (
        .is_div  (op_r[2]),
        .hi      (hi_r),
        .lo      (lo_r),
        .opnd    (opnd_r),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= MULDIV_ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MULDIV_ST_IDLE: if (accept) state_next = fast_path ? MULDIV_ST_FIX : MULDIV_ST_CALC;
            MULDIV_ST_CALC: if (cnt == 5'd0) state_next = MULDIV_ST_FIX;
            MULDIV_ST_FIX:  state_next = MULDIV_ST_DONE;
            MULDIV_ST_DONE: state_next = MULDIV_ST_IDLE;
            default:        state_next = MULDIV_ST_IDLE;
        endcase
    end

    // The accumulator holds a*b_unsigned; a negative signed multiplier is
    // corrected afterwards by subtracting a from the high word.
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        logic [32:0] ea, eb;
        logic [63:0] prod;
        ea     = {(op_r[1:0] != 2'b11) & a_r[31], a_r};
        eb     = {(op_r[1:0] == 2'b01) & b_r[31], b_r};
        prod   = $signed({{31{ea[32]}}, ea}) * $signed({{31{eb[32]}}, eb});
        mul_lo = prod[31:0];
        mul_hi = prod[63:32];
`else
        mul_lo = lo_r;
        mul_hi = hi_r[31:0] - (((op_r == M_MULH) && b_r[31]) ? a_r : 32'd0);
`endif
        res_fix = '0;
        case (op_r)
            M_MUL:                      res_fix = mul_lo;
            M_MULH, M_MULHSU, M_MULHU:  res_fix = mul_hi;
            M_DIV, M_DIVU:  res_fix = (b_r == 32'd0) ? 32'hFFFF_FFFF
                                      : (neg_q ? (~lo_r + 32'd1) : lo_r);
            M_REM, M_REMU:  res_fix = (b_r == 32'd0) ? a_r
                                      : (neg_r ? (~hi_r[31:0] + 32'd1) : hi_r[31:0]);
            default:        res_fix = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done   <= 1'b0;
            out    <= '0;
            cnt    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            opnd_r <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            res_r  <= '0;
        end else begin
            done <= (state == MULDIV_ST_DONE);
            case (state)
                MULDIV_ST_IDLE: begin
                    if (accept) begin
                        op_r <= funct3;
                        a_r  <= read1;
                        b_r  <= read2;
                        cnt  <= 5'd31;
                        hi_r <= '0;
                        if (funct3[2]) begin
                            lo_r   <= mag32(read1, !funct3[0]);
                            opnd_r <= {1'b0, mag32(read2, !funct3[0])};
                            neg_q  <= !funct3[0] && (read1[31] ^ read2[31]);
                            neg_r  <= !funct3[0] && read1[31];
                        end else begin
                            lo_r   <= read2;
                            opnd_r <= {(funct3[1:0] != 2'b11) & read1[31], read1};
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                        end
                    end
                end
                MULDIV_ST_CALC: begin
                    hi_r <= hi_next;
                    lo_r <= lo_next;
                    cnt  <= cnt - 5'd1;
                end
                MULDIV_ST_FIX:  res_r <= res_fix;
                MULDIV_ST_DONE: out   <= res_r;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; honours MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  funct3;
    logic [31:0] read1, read2, out;
    logic        busy, done;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_out = 32'd0;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .read1  (read1),
        .read2  (read2),
        .busy   (busy),
        .done   (done),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] exp, input string tag);
        int n;
        int lat;
        lat = f3[2] ? DIV_LAT : MUL_LAT;
        @(negedge clk);
        start = 1'b1; funct3 = f3; read1 = r1; read2 = r2;
        @(negedge clk);
        start = 1'b0; funct3 = f3 ^ 3'b101; read1 = $urandom; read2 = $urandom;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hold"}, out, last_out);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_out"}, out, exp);
        last_out = exp;
    endtask

    initial begin
        int n;
        int pulses;
        rst = 1'b1; start = 1'b0; funct3 = 3'd0; read1 = 32'd0; read2 = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out",  out, 32'd0);
        rst = 1'b0;

        run_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff");
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ff");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");
        run_op(3'b011, 32'h8000_0000, 32'd2,        32'h0000_0001, "mulhu_2^31x2");
        run_op(3'b001, 32'h8000_0000, 32'd2,        32'hFFFF_FFFF, "mulh_-2^31x2");
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "div_-7/2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "rem_-7/2");
        run_op(3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,        "div_-7/-2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "rem_-7/-2");
        run_op(3'b101, 32'd100,      32'd7,        32'd14,        "divu_100/7");
        run_op(3'b111, 32'd100,      32'd7,        32'd2,         "remu_100/7");
        run_op(3'b101, 32'hFFFF_FFFF, 32'h10,      32'h0FFF_FFFF, "divu_big");
        run_op(3'b111, 32'hFFFF_FFFF, 32'h10,      32'h0000_000F, "remu_big");
        run_op(3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, "div_by0");
        run_op(3'b111, 32'd5,        32'd0,        32'd5,         "remu_by0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        "rem_ovf");

        // Extra starts during a running divide must be ignored and not queue.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; read1 = 32'd100; read2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            start = (n == 4) || (n == 19);
            funct3 = 3'b000; read1 = 32'd3; read2 = 32'd3;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("ign_lat", n, DIV_LAT);
        chk("ign_out", out, 32'd14);
        last_out = 32'd14;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("ign_noqueue", pulses, 32'd0);
        chk("ign_idle_busy", {31'd0, busy}, 32'd0);

        // Back-to-back: each run_op starts in the cycle after the previous done.
        run_op(3'b000, 32'd6, 32'd7, 32'd42, "b2b_a");
        run_op(3'b101, 32'd9, 32'd2, 32'd4,  "b2b_b");
        run_op(3'b000, 32'd5, 32'd5, 32'd25, "b2b_c");

        // Reset at cycle 10 of a divide.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; read1 = 32'd100; read2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        chk("rstmid_out",  out, 32'd0);
        last_out = 32'd0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("rstmid_nodone", pulses, 32'd0);
        run_op(3'b000, 32'hFFFF_FFFE, 32'd21, 32'hFFFF_FFD6, "mul_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
